// File: rtl/demux4x32_buf_pkg.sv
// Shared definitions for the 1-to-4 buffered routing demultiplexer:
// destination select encodings and default geometry.
package demux4x32_buf_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam int NUM_DEST      = 4;

  typedef enum logic [1:0] {
    SEL_Y0 = 2'd0,
    SEL_Y1 = 2'd1,
    SEL_Y2 = 2'd2,
    SEL_Y3 = 2'd3
  } dest_sel_e;

endpackage

// File: rtl/demux4x32_buf_chan_fifo.sv
// Per-destination FIFO: power-of-two ring buffer with a separate occupancy
// counter so that full and empty are unambiguous.
module demux_chan_fifo
  import demux4x32_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             do_push, do_pop;

  assign full    = (fill_q == (AW+1)'(DEPTH));
  assign valid   = (fill_q != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  // NOTE: every variable gets its default first so no path through this block infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; fill_q alone decides what is live.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout = mem_q[rd_ptr_q];
  assign fill = fill_q;

endmodule

// File: rtl/demux4x32_buf.sv
// 1-to-4 routing demultiplexer: one valid/ready producer fanned out to four
// independently draining destination FIFOs selected by S.
module demux4x32_buf
  import demux4x32_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       S,
  input  logic             A_VALID,
  output logic             A_READY,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             Y0_VALID,
  output logic             Y1_VALID,
  output logic             Y2_VALID,
  output logic             Y3_VALID,
  input  logic             Y0_READY,
  input  logic             Y1_READY,
  input  logic             Y2_READY,
  input  logic             Y3_READY,
  output logic [AW:0]      FILL0,
  output logic [AW:0]      FILL1,
  output logic [AW:0]      FILL2,
  output logic [AW:0]      FILL3
);

  logic [NUM_DEST-1:0] sel_onehot;
  logic [NUM_DEST-1:0] push, pop, valid, full, cons_ready;
  logic [WIDTH-1:0]    dout [NUM_DEST];
  logic [AW:0]         fill [NUM_DEST];

  always_comb begin
    sel_onehot = '0;
    case (dest_sel_e'(S))
      SEL_Y0:  sel_onehot[0] = 1'b1;
      SEL_Y1:  sel_onehot[1] = 1'b1;
      SEL_Y2:  sel_onehot[2] = 1'b1;
      SEL_Y3:  sel_onehot[3] = 1'b1;
      default: sel_onehot    = '0;
    endcase
  end

  // Acceptance depends only on the registered fill of the selected FIFO, never on consumer ready.
  assign A_READY    = !RST && !full[S];
  assign push       = sel_onehot & {NUM_DEST{A_VALID && A_READY}};
  assign cons_ready = {Y3_READY, Y2_READY, Y1_READY, Y0_READY};
  assign pop        = valid & cons_ready;

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push[k]),
      .din   (A),
      .pop   (pop[k]),
      .dout  (dout[k]),
      .valid (valid[k]),
      .full  (full[k]),
      .fill  (fill[k])
    );
  end

  assign Y0       = dout[0];
  assign Y1       = dout[1];
  assign Y2       = dout[2];
  assign Y3       = dout[3];
  assign Y0_VALID = valid[0];
  assign Y1_VALID = valid[1];
  assign Y2_VALID = valid[2];
  assign Y3_VALID = valid[3];
  assign FILL0    = fill[0];
  assign FILL1    = fill[1];
  assign FILL2    = fill[2];
  assign FILL3    = fill[3];

endmodule

// File: tb/tb_demux4x32_buf.sv
// Scoreboard bench for demux4x32_buf: stimulus queues expected words per
// destination, a negedge monitor compares every pop against them.
module tb_demux4x32_buf;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [1:0]  s;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  y_ready;
  logic [31:0] y_data  [4];
  logic        y_valid [4];
  logic [2:0]  fill    [4];

  logic [31:0] exp_q [4][$];
  int n_checks = 0;
  int n_pass   = 0;

  demux4x32_buf dut (
    .CLK      (clk),
    .RST      (rst),
    .A        (a),
    .S        (s),
    .A_VALID  (a_valid),
    .A_READY  (a_ready),
    .Y0       (y_data[0]),
    .Y1       (y_data[1]),
    .Y2       (y_data[2]),
    .Y3       (y_data[3]),
    .Y0_VALID (y_valid[0]),
    .Y1_VALID (y_valid[1]),
    .Y2_VALID (y_valid[2]),
    .Y3_VALID (y_valid[3]),
    .Y0_READY (y_ready[0]),
    .Y1_READY (y_ready[1]),
    .Y2_READY (y_ready[2]),
    .Y3_READY (y_ready[3]),
    .FILL0    (fill[0]),
    .FILL1    (fill[1]),
    .FILL2    (fill[2]),
    .FILL3    (fill[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] data);
    a_valid = 1'b1;
    s       = sel;
    a       = data;
  endtask

  task automatic expect_word(input int k, input logic [31:0] data);
    exp_q[k].push_back(data);
  endtask

  // Monitor: every accepted pop outside reset must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (!rst && y_valid[k] && y_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("unexpected_pop_y%0d", k), y_data[k], 32'hxxxx_xxxx);
          end else begin
            check($sformatf("pop_y%0d", k), y_data[k], exp_q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; a = '0; s = 2'd0; a_valid = 1'b0; y_ready = 4'b0000;

    // Reset, then idle
    tick();
    @(negedge clk);
    check("ready_in_reset", {31'd0, a_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_fill%0d", k), {29'd0, fill[k]}, 32'd0);
      check($sformatf("rst_valid%0d", k), {31'd0, y_valid[k]}, 32'd0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, a_ready}, 32'd1);

    // Push to Y0 then Y2
    tick();
    drive(2'd0, 32'h1111_1111); expect_word(0, 32'h1111_1111);
    tick();
    drive(2'd2, 32'h2222_2222); expect_word(2, 32'h2222_2222);
    @(negedge clk);
    check("y0_valid_latency", {31'd0, y_valid[0]}, 32'd1);
    check("y0_data", y_data[0], 32'h1111_1111);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("y2_valid", {31'd0, y_valid[2]}, 32'd1);
    check("y2_data", y_data[2], 32'h2222_2222);
    check("fill0_one", {29'd0, fill[0]}, 32'd1);
    check("fill2_one", {29'd0, fill[2]}, 32'd1);
    check("y1_idle", {31'd0, y_valid[1]}, 32'd0);
    check("y3_idle", {31'd0, y_valid[3]}, 32'd0);

    // Fill FIFO1 to DEPTH; other destinations unaffected
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(2'd1, 32'hA0 + 32'(i)); expect_word(1, 32'hA0 + 32'(i));
    end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("fill1_full", {29'd0, fill[1]}, 32'd4);
    check("ready_full_s1", {31'd0, a_ready}, 32'd0);
    s = 2'd3;
    #1;
    check("ready_s3_while_1_full", {31'd0, a_ready}, 32'd1);
    tick();
    drive(2'd3, 32'hB0); expect_word(3, 32'hB0);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("fill3_after_b0", {29'd0, fill[3]}, 32'd1);
    check("fill1_still_full", {29'd0, fill[1]}, 32'd4);

    // Full FIFO1: pop with held push; push lands one cycle later
    tick();
    drive(2'd1, 32'hA4); y_ready = 4'b0010;
    @(negedge clk);
    check("ready_full_during_pop", {31'd0, a_ready}, 32'd0);
    tick();
    expect_word(1, 32'hA4); y_ready = 4'b1111;
    @(negedge clk);
    check("ready_after_pop", {31'd0, a_ready}, 32'd1);
    check("fill1_push_pop", {29'd0, fill[1]}, 32'd3);
    tick();
    a_valid = 1'b0;
    repeat (5) tick();
    y_ready = 4'b0000;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      check($sformatf("drained_fill%0d", k), {29'd0, fill[k]}, 32'd0);

    // Streaming push/pop on FIFO0 across pointer wrap
    y_ready = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(2'd0, 32'(i)); expect_word(0, 32'(i));
      if (i > 0) begin
        @(negedge clk);
        check($sformatf("stream_fill0_%0d", i), {29'd0, fill[0]}, 32'd1);
      end
    end
    tick();
    a_valid = 1'b0;
    tick();
    y_ready = 4'b0000;
    @(negedge clk);
    check("stream_fill0_end", {29'd0, fill[0]}, 32'd0);

    // Reset mid-operation with concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(2'd2, 32'hC0 + 32'(i)); expect_word(2, 32'hC0 + 32'(i));
    end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("fill2_three", {29'd0, fill[2]}, 32'd3);
    tick();
    rst = 1'b1; drive(2'd2, 32'hDEAD_BEEF); y_ready = 4'b0100;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    check("ready_mid_reset", {31'd0, a_ready}, 32'd0);
    tick();
    rst = 1'b0; a_valid = 1'b0; y_ready = 4'b0000;
    @(negedge clk);
    check("fill2_after_reset", {29'd0, fill[2]}, 32'd0);
    check("y2_valid_after_reset", {31'd0, y_valid[2]}, 32'd0);
    tick();
    drive(2'd2, 32'h5A); expect_word(2, 32'h5A);
    tick();
    a_valid = 1'b0; y_ready = 4'b0100;
    @(negedge clk);
    check("y2_after_reset_data", y_data[2], 32'h5A);
    check("fill2_single", {29'd0, fill[2]}, 32'd1);
    tick();
    @(negedge clk);
    check("fill2_final", {29'd0, fill[2]}, 32'd0);
    check("y2_valid_final", {31'd0, y_valid[2]}, 32'd0);
    y_ready = 4'b0000;

    for (int k = 0; k < 4; k++)
      check($sformatf("scoreboard_empty%0d", k), 32'(exp_q[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux4x32_buf.md
Name: demux4x32_buf

Overview:
- 1-to-4 routing demultiplexer with per-destination buffering. It is the counterpart of the 4:1 result-select mux.
- Accepts one 32-bit word per cycle on a valid/ready input, tagged with a 2-bit destination select S.
- Queues each word into the FIFO owned by the selected destination. Each destination drains independently over its own valid/ready port.
- Used to fan a single producer (e.g. writeback or load-return path) out to four consumers without stalling unrelated destinations.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, entries per destination FIFO. Power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width. Derived; not overridden.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  WIDTH  input data word.
- S  input  2  destination select: 00 to Y0, 01 to Y1, 10 to Y2, 11 to Y3.
- A_VALID  input  1  A/S valid this cycle.
- A_READY  output  1  block can accept the word on A for destination S.
- Y0..Y3  output  WIDTH each  head-of-FIFO data per destination.
- Y0_VALID..Y3_VALID  output  1 each  FIFO k non-empty.
- Y0_READY..Y3_READY  input  1 each  consumer k takes head this cycle.
- FILL0..FILL3  output  AW+1 each  current occupancy of FIFO k, 0..DEPTH.

Behaviour:
- Reset: synchronous, active-high; sampled on CLK rising edge.
  - All pointers, FILLk and Yk_VALID go to 0.
  - A_READY is 0 while RST is high.
  - Storage contents are not reset.
  - Reset mid-operation discards all queued words. Any push/pop in the reset cycle is ignored.
- Push: occurs when A_VALID && A_READY.
  - A_READY = !RST && (FILL[S] != DEPTH). It is combinational from S and the registered fill only.
  - There is no path from any Yk_READY to A_READY.
  - On push, A is written to FIFO[S] at its write pointer; that pointer increments modulo DEPTH.
- Pop: occurs on Yk_VALID && Yk_READY; FIFO k read pointer increments modulo DEPTH.
- Outputs:
  - Yk_VALID = (FILLk != 0), registered state.
  - Yk = entry at read pointer k. Don't-care when Yk_VALID = 0.
- Latency: a word pushed in cycle n is visible on Yk with Yk_VALID = 1 in cycle n+1 at the earliest. There is no same-cycle bypass.
- Ordering: per destination, strict FIFO order. There is no ordering guarantee across destinations.
- Simultaneous push and pop on the same FIFO:
  - When not full, both take effect and FILL is unchanged.
  - When full, no push occurs (A_READY = 0 that cycle), even if the pop occurs.
- Push into one FIFO and pops from any others proceed in the same cycle independently.
- Full FIFO k: stalls only words targeted at k. Input with S != k is unaffected.
- Empty FIFO k: Yk_READY is ignored. Pointers and FILLk do not change. There is no underflow.
- Wrap-around: pointers are AW bits and wrap naturally. FILLk is a separate AW+1-bit counter: +1 on push, -1 on pop, unchanged on both or neither.
- A_VALID = 0: S and A are ignored. A_READY still reflects FILL[S].
- A producer may drop A_VALID or change S while A_READY = 0. The block holds no input state.

Decomposition:
- Shared package: destination select encodings (SEL_Y0..SEL_Y3 = 2'd0..2'd3) and the default WIDTH/DEPTH constants.
- One sub-module, demux_chan_fifo, instantiated 4 times:
  - Parameters: WIDTH, DEPTH.
  - Ports: CLK, RST, push, din, pop, dout, valid, full, fill.
- The top level contains only the S decode to per-channel push, A_READY generation, and pop = Yk_VALID && Yk_READY.

Test Plan:
- Reset, then idle: all Yk_VALID = 0, FILLk = 0, A_READY = 0 during RST and 1 after.
- Push 0x11111111 with S=00, then 0x22222222 with S=10, all Yk_READY = 0:
  - Y0 = 0x11111111, Y0_VALID = 1 one cycle after its push.
  - Y2 = 0x22222222, Y2_VALID = 1.
  - FILL0 = FILL2 = 1; Y1_VALID = Y3_VALID = 0.
- Fill FIFO1 with 4 words 0xA0..0xA3 (DEPTH=4), Y1_READY = 0:
  - A_READY drops to 0 with S=01 but is 1 with S=11.
  - Push 0xB0 to Y3 and it succeeds while FIFO1 stays full.
- FIFO1 full, assert Y1_READY and hold A_VALID with S=01, data 0xA4:
  - Pop 0xA0 that cycle, no push that cycle.
  - The next cycle pushes 0xA4.
  - Drain order observed is 0xA1, 0xA2, 0xA3, 0xA4.
- Continuous push and pop on FIFO0 for 10 words 0..9 with Y0_READY = 1:
  - FILL0 stays at 1 after the first word.
  - Output sequence is 0..9 across pointer wrap.
- With 3 words queued in FIFO2, assert RST for one cycle concurrent with a push and a pop:
  - FILL2 = 0, Y2_VALID = 0 after reset.
  - A subsequent push of 0x5A appears alone on Y2.
